// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
//   Shared types and default geometry for the snake mover.
//   dir_t   : heading of the snake (left/up/down/right).
//   point_t : one grid cell, packed {x, y}.
//   state_t : step sequencer states of snake_mover.
//   decode_dir(): turns the one-hot L/U/D/R lines into a heading, holding the
//                 current heading when the lines are not exactly one-hot.
//   The coordinate widths of point_t come from the default grid size, so a
//   different grid size means editing the DEF_* values here.
// -----------------------------------------------------------------------------
package snake_pkg;

  localparam int DEF_GRID_W   = 16;
  localparam int DEF_GRID_H   = 16;
  localparam int DEF_MAX_LEN  = 32;
  localparam int DEF_INIT_LEN = 3;

  localparam int X_W = $clog2(DEF_GRID_W);
  localparam int Y_W = $clog2(DEF_GRID_H);

  typedef enum logic [1:0] {
    DIR_L = 2'd0,
    DIR_U = 2'd1,
    DIR_D = 2'd2,
    DIR_R = 2'd3
  } dir_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } point_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_MOVE  = 2'd2,
    ST_DEAD  = 2'd3
  } state_t;

  // Exactly one active line selects a new heading; anything else keeps cur.
  function automatic dir_t decode_dir(input logic l, input logic u,
                                      input logic d, input logic r,
                                      input dir_t cur);
    dir_t res;
    case ({l, u, d, r})
      4'b1000: res = DIR_L;
      4'b0100: res = DIR_U;
      4'b0010: res = DIR_D;
      4'b0001: res = DIR_R;
      default: res = cur;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// -----------------------------------------------------------------------------
// snake_next_head
//   Combinational: the cell one step from `cur` in direction `dir`, and whether
//   that cell lies off the grid.
//   Ports:
//     cur  in  point_t  current head cell
//     dir  in  dir_t    heading
//     nxt  out point_t  neighbouring cell (low bits only; meaningless when oob)
//     oob  out 1        neighbour is outside 0..GRID_W-1 x 0..GRID_H-1
//   The sum is formed one bit wider than a coordinate so that stepping left of
//   column 0 wraps to an all-ones value, which the range compare then rejects.
// -----------------------------------------------------------------------------
module snake_next_head
  import snake_pkg::*;
#(
  parameter int GRID_W = DEF_GRID_W,
  parameter int GRID_H = DEF_GRID_H
) (
  input  point_t cur,
  input  dir_t   dir,
  output point_t nxt,
  output logic   oob
);

  localparam logic [X_W:0] X_ONE = {{X_W{1'b0}}, 1'b1};
  localparam logic [Y_W:0] Y_ONE = {{Y_W{1'b0}}, 1'b1};

  logic [X_W:0] nx_s;
  logic [Y_W:0] ny_s;

  // Widened neighbour coordinate and range check.
  always_comb begin
    nx_s = {1'b0, cur.x};
    ny_s = {1'b0, cur.y};
    case (dir)
      DIR_L:   nx_s = {1'b0, cur.x} - X_ONE;
      DIR_R:   nx_s = {1'b0, cur.x} + X_ONE;
      DIR_U:   ny_s = {1'b0, cur.y} - Y_ONE;
      DIR_D:   ny_s = {1'b0, cur.y} + Y_ONE;
      default: begin
        nx_s = {1'b0, cur.x};
        ny_s = {1'b0, cur.y};
      end
    endcase
    oob   = (nx_s >= (X_W+1)'(GRID_W)) || (ny_s >= (Y_W+1)'(GRID_H));
    nxt.x = nx_s[X_W-1:0];
    nxt.y = ny_s[Y_W-1:0];
  end

endmodule

// File: rtl/snake_mover.sv
// -----------------------------------------------------------------------------
// snake_mover
//   Advances the snake one cell per accepted game tick, keeps the body as a
//   head-first segment list, applies growth and detects wall/self collisions.
//   Ports:
//     clk, reset          clock; synchronous active-high reset
//     tick                step request, only honoured while idle
//     Lin/Uin/Din/Rin     heading from the direction FSM (one-hot to change)
//     grow                food eaten; remembered until a move consumes it
//     head_x, head_y      current head cell
//     length              current number of segments
//     dead                sticky collision flag
//     step_done           one-cycle pulse after each completed move
//     query_x, query_y    renderer cell under test
//     query_hit           combinational: query cell is occupied by the snake
//   A step takes three edges: latch the candidate head (IDLE), test it
//   against walls and body (CHECK), then shift the body (MOVE). The pulse on
//   step_done therefore appears three cycles after the tick cycle, and ticks
//   arriving while a step is in flight are simply dropped.
// -----------------------------------------------------------------------------
module snake_mover
  import snake_pkg::*;
#(
  parameter int GRID_W   = DEF_GRID_W,
  parameter int GRID_H   = DEF_GRID_H,
  parameter int MAX_LEN  = DEF_MAX_LEN,
  parameter int INIT_LEN = DEF_INIT_LEN
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tick,
  input  logic                         Lin,
  input  logic                         Uin,
  input  logic                         Din,
  input  logic                         Rin,
  input  logic                         grow,
  output logic [$clog2(GRID_W)-1:0]    head_x,
  output logic [$clog2(GRID_H)-1:0]    head_y,
  output logic [$clog2(MAX_LEN+1)-1:0] length,
  output logic                         dead,
  output logic                         step_done,
  input  logic [$clog2(GRID_W)-1:0]    query_x,
  input  logic [$clog2(GRID_H)-1:0]    query_y,
  output logic                         query_hit
);

  localparam int                  LEN_BITS = $clog2(MAX_LEN+1);
  localparam logic [LEN_BITS-1:0] LEN_ONE  = {{(LEN_BITS-1){1'b0}}, 1'b1};
  localparam logic [LEN_BITS-1:0] LEN_MAX  = LEN_BITS'(MAX_LEN);
  localparam logic [LEN_BITS-1:0] LEN_INIT = LEN_BITS'(INIT_LEN);

  state_t              state_q,     state_d;
  dir_t                dir_q,       dir_d;
  point_t              seg_q [MAX_LEN];
  point_t              seg_d [MAX_LEN];
  logic [LEN_BITS-1:0] length_q,    length_d;
  logic                dead_q,      dead_d;
  logic                step_done_q, step_done_d;
  logic                grow_pend_q, grow_pend_d;
  point_t              nxt_q,       nxt_d;
  logic                oob_q,       oob_d;

  point_t              nh_s;
  logic                nh_oob_s;
  logic [LEN_BITS-1:0] lim_s;
  logic                self_hit_s;
  point_t              query_s;
  logic                query_hit_s;

  // Reset-time body: a horizontal line starting at the grid centre, tail to the right.
  function automatic point_t init_seg(input int idx);
    point_t p;
    if (idx < INIT_LEN) begin
      p.x = X_W'(GRID_W/2 + idx);
      p.y = Y_W'(GRID_H/2);
    end else begin
      p = '0;
    end
    return p;
  endfunction

  snake_next_head #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_next_head (
    .cur (seg_q[0]),
    .dir (dir_q),
    .nxt (nh_s),
    .oob (nh_oob_s)
  );

  // Self-collision against the live body; the tail cell is excluded unless the
  // snake is about to grow, because it vacates during the same move.
  always_comb begin
    if (grow_pend_q) begin
      lim_s = length_q;
    end else begin
      lim_s = length_q - LEN_ONE;
    end
    self_hit_s = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      self_hit_s = self_hit_s | ((LEN_BITS'(i) < lim_s) && (seg_q[i] == nxt_q));
    end
  end

  // Renderer lookup: parallel compare of the query cell against live segments.
  always_comb begin
    query_s.x   = query_x;
    query_s.y   = query_y;
    query_hit_s = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      query_hit_s = query_hit_s | ((LEN_BITS'(i) < length_q) && (seg_q[i] == query_s));
    end
  end

  // Step sequencer next state plus all datapath next values.
  always_comb begin
    state_d     = state_q;
    length_d    = length_q;
    dead_d      = dead_q;
    step_done_d = 1'b0;
    nxt_d       = nxt_q;
    oob_d       = oob_q;
    for (int i = 0; i < MAX_LEN; i++) begin
      seg_d[i] = seg_q[i];
    end
    dir_d       = decode_dir(Lin, Uin, Din, Rin, dir_q);
    grow_pend_d = grow_pend_q | grow;

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          nxt_d   = nh_s;
          oob_d   = nh_oob_s;
          state_d = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (oob_q || self_hit_s) begin
          dead_d  = 1'b1;
          state_d = ST_DEAD;
        end else begin
          state_d = ST_MOVE;
        end
      end
      ST_MOVE: begin
        for (int i = 1; i < MAX_LEN; i++) begin
          seg_d[i] = seg_q[i-1];
        end
        seg_d[0] = nxt_q;
        if (grow_pend_q && (length_q < LEN_MAX)) begin
          length_d = length_q + LEN_ONE;
        end else begin
          length_d = length_q;
        end
        // A grow arriving on the consuming edge is kept for the next step.
        grow_pend_d = grow;
        step_done_d = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_DEAD: begin
        grow_pend_d = grow_pend_q;
        state_d     = ST_DEAD;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset to the starting snake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      dir_q       <= DIR_L;
      length_q    <= LEN_INIT;
      dead_q      <= 1'b0;
      step_done_q <= 1'b0;
      grow_pend_q <= 1'b0;
      nxt_q       <= '0;
      oob_q       <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_q[i] <= init_seg(i);
      end
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      length_q    <= length_d;
      dead_q      <= dead_d;
      step_done_q <= step_done_d;
      grow_pend_q <= grow_pend_d;
      nxt_q       <= nxt_d;
      oob_q       <= oob_d;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_q[i] <= seg_d[i];
      end
    end
  end

  assign head_x    = seg_q[0].x;
  assign head_y    = seg_q[0].y;
  assign length    = length_q;
  assign dead      = dead_q;
  assign step_done = step_done_q;
  assign query_hit = query_hit_s;

endmodule

// File: tb/tb_snake_mover.sv
// -----------------------------------------------------------------------------
// tb_snake_mover
//   Bench for snake_mover at default geometry (16x16, 32 segments, start 3).
//   A queue-based model of the snake tracks body, heading, pending growth and
//   the three-cycle step timing; a compare process checks every output against
//   it after each clock edge. Directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_snake_mover;

  localparam int GW = 16;
  localparam int GH = 16;
  localparam int ML = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       Lin = 1'b1, Uin = 1'b0, Din = 1'b0, Rin = 1'b0;
  logic       grow = 1'b0;
  logic [3:0] head_x, head_y;
  logic [5:0] length;
  logic       dead, step_done;
  logic [3:0] query_x = 4'd0, query_y = 4'd0;
  logic       query_hit;

  int n_pass = 0;
  int n_total = 0;

  snake_mover dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .Lin       (Lin),
    .Uin       (Uin),
    .Din       (Din),
    .Rin       (Rin),
    .grow      (grow),
    .head_x    (head_x),
    .head_y    (head_y),
    .length    (length),
    .dead      (dead),
    .step_done (step_done),
    .query_x   (query_x),
    .query_y   (query_y),
    .query_hit (query_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {int x; int y;} mp_t;
  mp_t body[$];
  int  m_dx, m_dy;
  bit  m_grow, m_dead, m_sd, m_oob;
  int  m_phase;          // 0 waiting for tick, 1 candidate latched, 2 cleared to move
  mp_t m_nxt;

  function automatic bit m_has(input int x, input int y, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (body[i].x == x && body[i].y == y) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_edge();
    bit  dead_before;
    int  lim;
    int  n;
    if (reset) begin
      body.delete();
      for (int i = 0; i < 3; i++) body.push_back('{GW/2 + i, GH/2});
      m_dx = -1; m_dy = 0;
      m_grow = 0; m_dead = 0; m_sd = 0; m_phase = 0;
    end else begin
      dead_before = m_dead;
      m_sd = 0;
      if (m_phase == 0) begin
        if (!m_dead && tick) begin
          m_nxt.x = body[0].x + m_dx;
          m_nxt.y = body[0].y + m_dy;
          m_oob = (m_nxt.x < 0) || (m_nxt.x >= GW) || (m_nxt.y < 0) || (m_nxt.y >= GH);
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        lim = m_grow ? body.size() : body.size() - 1;
        if (m_oob || m_has(m_nxt.x, m_nxt.y, lim)) begin
          m_dead = 1;
          m_phase = 0;
        end else begin
          m_phase = 2;
        end
      end else begin
        n = body.size();
        body.push_front(m_nxt);
        if (!(m_grow && n < ML)) void'(body.pop_back());
        m_grow = 0;
        m_sd = 1;
        m_phase = 0;
      end
      if (grow && !dead_before) m_grow = 1;
      if (int'(Lin) + int'(Uin) + int'(Din) + int'(Rin) == 1) begin
        if (Lin) begin m_dx = -1; m_dy = 0; end
        if (Rin) begin m_dx = 1;  m_dy = 0; end
        if (Uin) begin m_dx = 0;  m_dy = -1; end
        if (Din) begin m_dx = 0;  m_dy = 1; end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_edge();
    end
  end

  // Compare process: every cycle, shortly after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("cmp_head_x", int'(head_x), body[0].x);
      chk("cmp_head_y", int'(head_y), body[0].y);
      chk("cmp_length", int'(length), body.size());
      chk("cmp_dead", int'(dead), int'(m_dead));
      chk("cmp_step_done", int'(step_done), int'(m_sd));
      chk("cmp_query_hit", int'(query_hit),
          int'(m_has(int'(query_x), int'(query_y), body.size())));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic set_query(input int x, input int y);
    query_x = 4'(x);
    query_y = 4'(y);
    #1;
  endtask

  // Called at a negedge; returns at the negedge where step_done would show.
  task automatic do_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_dir(input logic l, input logic u, input logic d, input logic r);
    Lin = l; Uin = u; Din = d; Rin = r;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_head_x", int'(head_x), 8);
    chk("rst_head_y", int'(head_y), 8);
    chk("rst_length", int'(length), 3);
    chk("rst_dead", int'(dead), 0);
    chk("rst_step_done", int'(step_done), 0);
    set_query(10, 8);
    chk("rst_query_tail", int'(query_hit), 1);
    set_query(11, 8);
    chk("rst_query_beyond", int'(query_hit), 0);

    // First step left with latency check
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    chk("lat_not_early", int'(step_done), 0);
    @(negedge clk);
    chk("lat_done", int'(step_done), 1);
    chk("step1_head_x", int'(head_x), 7);
    chk("step1_head_y", int'(head_y), 8);
    set_query(10, 8);
    chk("step1_old_tail", int'(query_hit), 0);
    @(negedge clk);
    chk("done_one_cycle", int'(step_done), 0);

    // March to the left wall, then off it
    for (int k = 0; k < 7; k++) do_tick();
    chk("wall_head_x", int'(head_x), 0);
    chk("wall_dead_before", int'(dead), 0);
    do_tick();
    chk("wall_dead", int'(dead), 1);
    chk("wall_head_held", int'(head_x), 0);
    chk("wall_no_done", int'(step_done), 0);
    do_tick();
    chk("dead_head_held", int'(head_x), 0);
    chk("dead_len_held", int'(length), 3);

    // Growth retains the tail
    apply_reset();
    grow = 1'b1;
    @(negedge clk);
    grow = 1'b0;
    do_tick();
    chk("grow_len", int'(length), 4);
    set_query(10, 8);
    chk("grow_tail_kept", int'(query_hit), 1);

    // Tick held into CHECK yields a single step
    tick = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    chk("held_tick_x", int'(head_x), 6);
    @(negedge clk);
    @(negedge clk);
    chk("held_tick_once", int'(head_x), 6);

    // Multi-hot keeps heading left
    set_dir(1'b1, 1'b0, 1'b0, 1'b1);
    do_tick();
    chk("multihot_x", int'(head_x), 5);
    chk("multihot_alive", int'(dead), 0);

    // Reversal into the neck
    apply_reset();
    set_dir(1'b0, 1'b0, 1'b0, 1'b1);
    do_tick();
    chk("reverse_dead", int'(dead), 1);
    chk("reverse_head_x", int'(head_x), 8);
    set_dir(1'b1, 1'b0, 1'b0, 1'b0);

    // Reset during MOVE aborts the step
    apply_reset();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_head_x", int'(head_x), 8);
    chk("abort_len", int'(length), 3);
    chk("abort_done", int'(step_done), 0);
    @(negedge clk);
    chk("abort_no_late_done", int'(step_done), 0);

    // Saturating growth: up 8, left 8, down 15 with grow held
    apply_reset();
    set_dir(1'b0, 1'b1, 1'b0, 1'b0);
    grow = 1'b1;
    for (int k = 0; k < 8; k++) do_tick();
    set_dir(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) do_tick();
    set_dir(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 15; k++) do_tick();
    grow = 1'b0;
    chk("sat_len", int'(length), 32);
    chk("sat_head_x", int'(head_x), 0);
    chk("sat_head_y", int'(head_y), 15);
    chk("sat_alive", int'(dead), 0);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
